// File: rtl/spike_monitor.sv
// spike_monitor: threshold-crossing spike detector with refractory hold-off and a windowed,
// saturating spike-rate counter. Define SPIKE_MONITOR_HYST_EN to enable the WAIT_REARM hysteresis state.
module spike_monitor #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
  parameter int unsigned REFRACTORY    = 4,
  parameter logic [7:0]  HYST          = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] V_mem,
  input  logic [7:0] v_thresh,
  output logic       spike,
  output logic       refractory,
  output logic [7:0] rate_count,
  output logic       rate_valid
);

  typedef enum logic [1:0] {
    ST_ARMED      = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACT    = 2'd2,
    ST_WAIT_REARM = 2'd3
  } state_t;

  localparam logic [7:0]  LP_REFR_LEN = 8'(REFRACTORY);
  localparam logic [23:0] LP_WIN_LAST = WINDOW_CYCLES - 24'd1;

  // Where the FSM goes once the refractory hold-off (if any) is over.
`ifdef SPIKE_MONITOR_HYST_EN
  localparam state_t LP_POST_FIRE = ST_WAIT_REARM;
`else
  localparam state_t LP_POST_FIRE = ST_ARMED;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_refr_cnt;
  logic [23:0] r_win_cnt;
  logic [7:0]  r_running;
  logic [7:0]  r_rate_count;
  logic        r_spike;
  logic        r_rate_valid;

  logic        w_cross;
  logic        w_rearm_ok;
  logic        w_fire;
  logic        w_in_refract;
  logic        w_win_term;
  logic [8:0]  w_rearm_diff;
  logic [7:0]  w_rearm;
  logic [8:0]  w_sum;
  logic [7:0]  w_sum_sat;

  assign w_cross      = (V_mem >= v_thresh);
  // Re-arm level is threshold minus hysteresis, clamped at zero through a 9-bit borrow.
  assign w_rearm_diff = {1'b0, v_thresh} - {1'b0, HYST};
  assign w_rearm      = w_rearm_diff[8] ? 8'd0 : w_rearm_diff[7:0];
  assign w_rearm_ok   = (V_mem <= w_rearm);

  assign w_win_term   = (r_win_cnt == LP_WIN_LAST);
  assign w_sum        = {1'b0, r_running} + {8'd0, r_spike};
  assign w_sum_sat    = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARMED;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARMED:      if (w_cross) w_state_next = ST_FIRE;
      ST_FIRE:       w_state_next = (REFRACTORY > 0) ? ST_REFRACT : LP_POST_FIRE;
      ST_REFRACT:    if (r_refr_cnt <= 8'd1) w_state_next = LP_POST_FIRE;
      ST_WAIT_REARM: if (w_rearm_ok) w_state_next = ST_ARMED;
      default:       w_state_next = ST_ARMED;
    endcase
  end

  always_comb begin
    w_fire       = ena && (r_state == ST_ARMED) && w_cross;
    w_in_refract = (r_state == ST_REFRACT);
  end

  // Down-counter is loaded while leaving FIRE so REFRACT sees the full length on its first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refr_cnt <= 8'd0;
    end else if (ena) begin
      if (r_state == ST_FIRE) begin
        r_refr_cnt <= LP_REFR_LEN;
      end else if (r_state == ST_REFRACT) begin
        r_refr_cnt <= r_refr_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike <= 1'b0;
    end else begin
      r_spike <= w_fire;
    end
  end

  // The spike pulse visible during the terminal cycle closes out into the finishing window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt    <= 24'd0;
      r_running    <= 8'd0;
      r_rate_count <= 8'd0;
      r_rate_valid <= 1'b0;
    end else if (!ena) begin
      r_rate_valid <= 1'b0;
    end else if (w_win_term) begin
      r_win_cnt    <= 24'd0;
      r_running    <= 8'd0;
      r_rate_count <= w_sum_sat;
      r_rate_valid <= 1'b1;
    end else begin
      r_win_cnt    <= r_win_cnt + 24'd1;
      r_running    <= w_sum_sat;
      r_rate_valid <= 1'b0;
    end
  end

  assign spike      = r_spike;
  assign refractory = w_in_refract;
  assign rate_count = r_rate_count;
  assign rate_valid = r_rate_valid;

endmodule

// File: tb/tb_spike_monitor.sv
// Bench for spike_monitor: two instances (R=4/W=20 and R=0/W=1000) checked every cycle against
// an event-time model, plus hand-computed expectations per directed phase.
module tb_spike_monitor;
  localparam int R_A  = 4;
  localparam int R_B  = 0;
  localparam int W_A  = 20;
  localparam int W_B  = 1000;
  localparam int HYST = 16;

`ifdef SPIKE_MONITOR_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] v_mem = 8'd0;
  logic [7:0] v_th = 8'd0;
  logic [1:0] spike_o;
  logic [1:0] refr_o;
  logic [1:0] valid_o;
  logic [7:0] rate_o [2];

  always #5 clk = ~clk;

  spike_monitor #(.WINDOW_CYCLES(24'd20), .REFRACTORY(R_A), .HYST(8'd16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .V_mem(v_mem), .v_thresh(v_th),
    .spike(spike_o[0]), .refractory(refr_o[0]), .rate_count(rate_o[0]), .rate_valid(valid_o[0]));

  spike_monitor #(.WINDOW_CYCLES(24'd1000), .REFRACTORY(R_B), .HYST(8'd16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .V_mem(v_mem), .v_thresh(v_th),
    .spike(spike_o[1]), .refractory(refr_o[1]), .rate_count(rate_o[1]), .rate_valid(valid_o[1]));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: enabled-edge index, earliest firing edge, pending re-arm, last fire edge, window tally.
  int m_n [2];
  int m_can [2];
  int m_wfrom [2];
  int m_last [2];
  int m_run [2];
  bit m_wait [2];
  bit m_fired [2];
  bit e_spike [2];
  bit e_refr [2];
  bit e_valid [2];
  int e_rate [2];

  int n_spk, n_ref, n_val;

  function automatic int rlen(input int k);
    return (k == 0) ? R_A : R_B;
  endfunction

  function automatic int wlen(input int k);
    return (k == 0) ? W_A : W_B;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_can[k] = 0; m_wfrom[k] = 0; m_last[k] = 0; m_run[k] = 0;
      m_wait[k] = 1'b0; m_fired[k] = 1'b0;
      e_spike[k] = 1'b0; e_refr[k] = 1'b0; e_valid[k] = 1'b0; e_rate[k] = 0;
    end
  endtask

  task automatic model_edge();
    int rearm;
    rearm = (int'(v_th) >= HYST) ? int'(v_th) - HYST : 0;
    for (int k = 0; k < 2; k++) begin
      if (!ena) begin
        e_spike[k] = 1'b0;
        e_valid[k] = 1'b0;
      end else begin
        int n;
        int tot;
        bit fire;
        n = m_n[k];
        fire = 1'b0;
        if (!m_wait[k] && n >= m_can[k] && int'(v_mem) >= int'(v_th)) begin
          fire = 1'b1;
          m_last[k] = n;
          m_fired[k] = 1'b1;
          if (HYST_ON) begin
            m_wait[k] = 1'b1;
            m_wfrom[k] = n + rlen(k) + 2;
          end else begin
            m_can[k] = n + rlen(k) + 2;
          end
        end else if (m_wait[k] && n >= m_wfrom[k] && int'(v_mem) <= rearm) begin
          m_wait[k] = 1'b0;
          m_can[k] = n + 1;
        end
        tot = m_run[k] + int'(e_spike[k]);
        if ((n % wlen(k)) == wlen(k) - 1) begin
          e_rate[k] = (tot > 255) ? 255 : tot;
          m_run[k] = 0;
          e_valid[k] = 1'b1;
        end else begin
          m_run[k] = (tot > 255) ? 255 : tot;
          e_valid[k] = 1'b0;
        end
        e_spike[k] = fire;
        e_refr[k] = m_fired[k] && (n >= m_last[k] + 1) && (n <= m_last[k] + rlen(k));
        m_n[k] = n + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("spike[%0d]", k), int'(spike_o[k]), int'(e_spike[k]));
        chk($sformatf("refractory[%0d]", k), int'(refr_o[k]), int'(e_refr[k]));
        chk($sformatf("rate_count[%0d]", k), int'(rate_o[k]), e_rate[k]);
        chk($sformatf("rate_valid[%0d]", k), int'(valid_o[k]), int'(e_valid[k]));
      end
    end
  end

  // One clock: drive at the falling edge, advance the model at the rising edge, return at the next fall.
  task automatic cyc(input int v, input int th, input bit en);
    v_mem = 8'(v);
    v_th  = 8'(th);
    ena   = en;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    n_spk += int'(spike_o[0]);
    n_ref += int'(refr_o[0]);
    n_val += int'(valid_o[0]);
  endtask

  task automatic clr();
    n_spk = 0; n_ref = 0; n_val = 0;
  endtask

  initial begin
    int last_b;
    int nb;
    clr();
    model_reset();
    cmp_en = 1'b1;

    rst_n = 1'b0;
    repeat (3) cyc(0, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("rst_spike", int'(spike_o[k]), 0);
      chk("rst_refr", int'(refr_o[k]), 0);
      chk("rst_rate", int'(rate_o[k]), 0);
      chk("rst_valid", int'(valid_o[k]), 0);
    end
    rst_n = 1'b1;

    // Window of 20: spikes sampled on enabled edges 1,7,13,19 (or 1,8,19 with hysteresis).
    clr();
    for (int i = 0; i < 20; i++) begin
      if (HYST_ON) cyc((i == 0 || i == 7 || i == 18) ? 120 : 0, 100, 1'b1);
      else         cyc(120, 100, 1'b1);
      if (i == 0) chk("first_latency", int'(spike_o[0]), 1);
    end
    chk("win_rate", int'(rate_o[0]), HYST_ON ? 3 : 4);
    chk("win_valid_pulses", n_val, 1);
    cyc(0, 100, 1'b1);
    chk("win_valid_drop", int'(valid_o[0]), 0);
    repeat (19) cyc(0, 100, 1'b1);
    chk("win2_rate", int'(rate_o[0]), 0);
    chk("win2_valid", int'(valid_o[0]), 1);
    $display("window: rate=%0d then %0d", HYST_ON ? 3 : 4, rate_o[0]);
    repeat (10) cyc(0, 100, 1'b1);

    // Single crossing 50 -> 120 -> 80, then a second crossing proving re-arm.
    clr();
    for (int i = 0; i < 23; i++) begin
      cyc((i < 3) ? 50 : (i < 6) ? 120 : (i < 14) ? 80 : (i == 14) ? 120 : 0, 100, 1'b1);
      if (i == 3) chk("sc_spike_edge", int'(spike_o[0]), 1);
    end
    chk("sc_spikes", n_spk, 2);
    chk("sc_refr_cycles", n_ref, 8);
    $display("single crossing: spikes=%0d refractory cycles=%0d", n_spk, n_ref);
    repeat (10) cyc(0, 100, 1'b1);

    // Oscillation 120/90 around threshold 100.
    clr();
    for (int i = 0; i < 30; i++) cyc((i % 2 == 0) ? 120 : 90, 100, 1'b1);
    chk("hyst_spikes", n_spk, HYST_ON ? 1 : 5);
    $display("hysteresis: spikes=%0d", n_spk);
    repeat (10) cyc(0, 100, 1'b1);

    // Enable dropped for 10 cycles in the middle of REFRACT.
    clr();
    cyc(120, 100, 1'b1);
    cyc(0, 100, 1'b1);
    cyc(0, 100, 1'b1);
    repeat (10) begin
      cyc(0, 100, 1'b0);
      chk("frz_refr", int'(refr_o[0]), 1);
    end
    repeat (8) cyc(0, 100, 1'b1);
    chk("frz_refr_total", n_ref, 14);
    $display("enable freeze: refractory cycles=%0d", n_ref);
    repeat (10) cyc(0, 100, 1'b1);

    // Threshold 10 with HYST 16: re-arm level clamps to 0.
    clr();
    cyc(50, 10, 1'b1);
    repeat (10) cyc(15, 10, 1'b1);
    cyc(0, 10, 1'b1);
    cyc(50, 10, 1'b1);
    repeat (8) cyc(0, 10, 1'b1);
    chk("low_thresh_spikes", n_spk, HYST_ON ? 2 : 3);
    $display("low threshold: spikes=%0d", n_spk);

    // Saturation: instance B fires every third cycle over a 1000-cycle window.
    last_b = -1;
    nb = 0;
    for (int i = 0; i < 2100; i++) begin
      cyc((i % 3 == 2) ? 0 : 200, 10, 1'b1);
      if (valid_o[1]) begin
        last_b = int'(rate_o[1]);
        nb++;
      end
    end
    chk("sat_rate", last_b, 255);
    chk("sat_window_seen", int'(nb >= 1), 1);
    $display("saturation: windows=%0d rate=%0d", nb, last_b);
    repeat (10) cyc(0, 100, 1'b1);

    // Asynchronous reset in the middle of REFRACT.
    cyc(120, 100, 1'b1);
    cyc(0, 100, 1'b1);
    cyc(0, 100, 1'b1);
    chk("pre_rst_refr", int'(refr_o[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_spike", int'(spike_o[k]), 0);
      chk("arst_refr", int'(refr_o[k]), 0);
      chk("arst_rate", int'(rate_o[k]), 0);
      chk("arst_valid", int'(valid_o[k]), 0);
    end
    model_reset();
    @(negedge clk);
    repeat (2) cyc(0, 100, 1'b1);
    rst_n = 1'b1;
    cyc(120, 100, 1'b1);
    chk("post_rst_latency", int'(spike_o[0]), 1);
    repeat (5) cyc(0, 100, 1'b1);
    $display("async reset: outputs cleared, re-fired after release");

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
